// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared tile types, grid/screen dimensions, FSM states and level layouts
package tile_pkg;

  localparam logic [1:0] TILE_BG    = 2'b00;
  localparam logic [1:0] TILE_FLOOR = 2'b01;
  localparam logic [1:0] TILE_GIFT  = 2'b10;
  localparam logic [1:0] TILE_HOLE  = 2'b11;

  localparam int GRID_COLS_C = 8;
  localparam int GRID_ROWS_C = 6;
  localparam int GRID_CELLS  = GRID_COLS_C * GRID_ROWS_C;

  localparam logic [10:0] SCREEN_W = 11'd640;
  localparam logic [10:0] SCREEN_H = 11'd480;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD_PEND = 2'd1,
    ST_LOAD      = 2'd2
  } state_t;

  // Level layouts, one row of the grid per line (index = row*8 + col).
  localparam logic [1:0] LEVEL_LAYOUT [4][GRID_CELLS] = '{
    '{TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_GIFT,  TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_HOLE,  TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR},
    '{TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_GIFT,  TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_FLOOR, TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_HOLE,  TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR},
    '{TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_GIFT,  TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_HOLE,  TILE_FLOOR, TILE_FLOOR},
    '{TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_GIFT,  TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,    TILE_BG,
      TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_FLOOR, TILE_HOLE}
  };

endpackage

// File: rtl/tile_locator.sv
// rtl/tile_locator.sv - pixel coordinate to tile column/row/offset, combinational
module tile_locator
  import tile_pkg::*;
#(
  parameter int TILE_W    = 80,
  parameter int TILE_H    = 80,
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 6
) (
  input  logic [10:0] px,
  input  logic [10:0] py,
  output logic [2:0]  col,
  output logic [2:0]  row,
  output logic [10:0] off_x,
  output logic [10:0] off_y,
  output logic        in_range
);

  // Constant-divisor comparator chain: the last tile boundary not above the coordinate wins.
  always_comb begin
    col      = '0;
    row      = '0;
    off_x    = px;
    off_y    = py;
    in_range = (px < 11'(GRID_COLS * TILE_W)) && (py < 11'(GRID_ROWS * TILE_H));
    for (int c = 1; c < GRID_COLS; c++) begin
      if (px >= 11'(c * TILE_W)) begin
        col   = 3'(c);
        off_x = px - 11'(c * TILE_W);
      end
    end
    for (int r = 1; r < GRID_ROWS; r++) begin
      if (py >= 11'(r * TILE_H)) begin
        row   = 3'(r);
        off_y = py - 11'(r * TILE_H);
      end
    end
  end

endmodule

// File: rtl/tile_grid_controller.sv
// rtl/tile_grid_controller.sv - tile grid owner: display/query reads, vblank-deferred updates and level loads
module tile_grid_controller
  import tile_pkg::*;
#(
  parameter int TILE_W     = 80,
  parameter int TILE_H     = 80,
  parameter int GRID_COLS  = 8,
  parameter int GRID_ROWS  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [1:0]  Tile_type,
  input  logic        wr_req,
  input  logic [2:0]  wr_col,
  input  logic [2:0]  wr_row,
  input  logic [1:0]  wr_type,
  output logic        wr_ack,
  output logic        fifo_full,
  input  logic        load_req,
  input  logic [1:0]  load_level,
  output logic        busy,
  output logic        load_done,
  input  logic [2:0]  rd_col,
  input  logic [2:0]  rd_row,
  output logic [1:0]  rd_type
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [1:0]  grid [GRID_CELLS];
  state_t      state, state_nxt;
  logic [1:0]  level_q;
  logic [5:0]  load_idx;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;

  logic        vblank, push, pop, fifo_empty;
  logic        latch_level, flush, load_wr, load_last;
  logic [7:0]  pop_entry;
  logic [2:0]  pop_col, pop_row;
  logic [1:0]  pop_type;

  logic [2:0]  loc_col, loc_row;
  logic [10:0] loc_offx, loc_offy;
  logic        loc_in;

  tile_locator #(
    .TILE_W    (TILE_W),
    .TILE_H    (TILE_H),
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS)
  ) u_locator (
    .px       (pixelX),
    .py       (pixelY),
    .col      (loc_col),
    .row      (loc_row),
    .off_x    (loc_offx),
    .off_y    (loc_offy),
    .in_range (loc_in)
  );

  assign vblank     = (pixelY >= SCREEN_H);
  assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = wr_req && !fifo_full && (state == ST_IDLE);
  assign pop        = (state == ST_IDLE) && vblank && !fifo_empty;
  assign pop_entry  = fifo_mem[rd_ptr];
  assign pop_col    = pop_entry[7:5];
  assign pop_row    = pop_entry[4:2];
  assign pop_type   = pop_entry[1:0];
  assign busy       = (state != ST_IDLE);

  // Next-state logic: load waits for vblank, then copies the layout one cell per cycle.
  always_comb begin
    state_nxt   = state;
    latch_level = 1'b0;
    flush       = 1'b0;
    load_wr     = 1'b0;
    load_last   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_req) begin
          state_nxt   = ST_LOAD_PEND;
          latch_level = 1'b1;
        end
      end
      ST_LOAD_PEND: begin
        if (vblank) begin
          state_nxt = ST_LOAD;
          flush     = 1'b1;
        end
      end
      ST_LOAD: begin
        load_wr = 1'b1;
        if (load_idx == 6'(GRID_CELLS - 1)) begin
          load_last = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, latched level, load cell counter and done pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      level_q   <= '0;
      load_idx  <= '0;
      load_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= load_last;
      if (latch_level) level_q <= load_level;
      if (flush)        load_idx <= '0;
      else if (load_wr) load_idx <= load_idx + 1'b1;
    end
  end

  // Update queue storage; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {wr_col, wr_row, wr_type};
  end

  // Update queue pointers and occupancy; a load start discards pending entries.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= push;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Grid storage: layout copy during load, drained updates otherwise; off-grid rows are dropped.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < GRID_CELLS; i++) grid[i] <= TILE_BG;
    end else if (load_wr) begin
      grid[load_idx] <= LEVEL_LAYOUT[level_q][load_idx];
    end else if (pop && (pop_row < 3'(GRID_ROWS))) begin
      grid[{pop_row, pop_col}] <= pop_type;
    end
  end

  // Registered display and query read ports.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      offsetX   <= '0;
      offsetY   <= '0;
      Tile_type <= TILE_BG;
      rd_type   <= TILE_BG;
    end else begin
      if (loc_in) begin
        offsetX   <= loc_offx;
        offsetY   <= loc_offy;
        Tile_type <= grid[{loc_row, loc_col}];
      end else begin
        offsetX   <= '0;
        offsetY   <= '0;
        Tile_type <= TILE_BG;
      end
      rd_type <= (rd_row < 3'(GRID_ROWS)) ? grid[{rd_row, rd_col}] : TILE_BG;
    end
  end

endmodule

// File: tb/tb_tile_grid_controller.sv
// tb/tb_tile_grid_controller.sv - self-checking bench for tile_grid_controller
module tb_tile_grid_controller;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic [10:0] offsetX, offsetY;
  logic [1:0]  Tile_type;
  logic        wr_req;
  logic [2:0]  wr_col, wr_row;
  logic [1:0]  wr_type;
  logic        wr_ack, fifo_full;
  logic        load_req;
  logic [1:0]  load_level;
  logic        busy, load_done;
  logic [2:0]  rd_col, rd_row;
  logic [1:0]  rd_type;

  tile_grid_controller dut (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .offsetX(offsetX), .offsetY(offsetY), .Tile_type(Tile_type),
    .wr_req(wr_req), .wr_col(wr_col), .wr_row(wr_row), .wr_type(wr_type),
    .wr_ack(wr_ack), .fifo_full(fifo_full), .load_req(load_req), .load_level(load_level),
    .busy(busy), .load_done(load_done), .rd_col(rd_col), .rd_row(rd_row), .rd_type(rd_type)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: whole-grid array, queue of pending updates, and a mode (0 idle, 1 pending, 2 loading).
  int m_grid [48];
  int mq [$];
  int m_mode, m_level, m_cnt;

  typedef struct {
    int px; int py; int ox; int oy; int t;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Level rule: bottom row floor with one hole at col 2L+1, gift at row 2 col L+2, floor at row 3 cols 0..L.
  function automatic int lay(input int l, input int i);
    int r, c;
    r = i / 8;
    c = i % 8;
    if (r == 5) return (c == 2 * l + 1) ? 3 : 1;
    if (r == 2 && c == l + 2) return 2;
    if (r == 3 && c <= l) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 48; i++) m_grid[i] = 0;
    mq.delete();
    m_mode = 0; m_level = 0; m_cnt = 0;
  endtask

  // One clock: predict from pre-edge model state and inputs, advance model, then compare.
  task automatic tick();
    int ex_ox, ex_oy, ex_t, ex_rd, pre, e;
    bit ex_ack, ex_done, do_push, do_pop;
    ex_ox = 0; ex_oy = 0; ex_t = 0;
    if (pixelX < 640 && pixelY < 480) begin
      ex_ox = pixelX % 80;
      ex_oy = pixelY % 80;
      ex_t  = m_grid[(pixelY / 80) * 8 + pixelX / 80];
    end
    ex_rd = (rd_row < 6) ? m_grid[rd_row * 8 + rd_col] : 0;
    ex_ack = 0; ex_done = 0;
    case (m_mode)
      0: begin
        pre = mq.size();
        do_push = wr_req && pre < 4;
        do_pop  = (pixelY >= 480) && pre > 0;
        if (do_pop) begin
          e = mq.pop_front();
          if (((e >> 2) & 7) < 6) m_grid[((e >> 2) & 7) * 8 + (e >> 5)] = e & 3;
        end
        if (do_push) mq.push_back(wr_col * 32 + wr_row * 4 + wr_type);
        ex_ack = do_push;
        if (load_req) begin m_mode = 1; m_level = load_level; end
      end
      1: if (pixelY >= 480) begin m_mode = 2; m_cnt = 0; mq.delete(); end
      default: begin
        m_grid[m_cnt] = lay(m_level, m_cnt);
        if (m_cnt == 47) begin m_mode = 0; ex_done = 1; end
        else m_cnt++;
      end
    endcase
    @(posedge clk);
    #1;
    chk("offsetX", offsetX, ex_ox);
    chk("offsetY", offsetY, ex_oy);
    chk("Tile_type", Tile_type, ex_t);
    chk("rd_type", rd_type, ex_rd);
    chk("wr_ack", wr_ack, ex_ack);
    chk("load_done", load_done, ex_done);
    chk("busy", busy, m_mode != 0);
    chk("fifo_full", fifo_full, mq.size() == 4);
  endtask

  task automatic chk_reset_vals();
    chk("rst_offsetX", offsetX, 0);
    chk("rst_offsetY", offsetY, 0);
    chk("rst_Tile_type", Tile_type, 0);
    chk("rst_rd_type", rd_type, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_done", load_done, 0);
  endtask

  task automatic scan_grid(input int lvl, input bit use_layout);
    for (int i = 0; i < 48; i++) begin
      rd_row = 3'(i / 8);
      rd_col = 3'(i % 8);
      tick();
      chk("grid_scan", rd_type, use_layout ? lay(lvl, i) : 0);
    end
  endtask

  task automatic idle_inputs();
    wr_req = 0; load_req = 0; wr_col = 0; wr_row = 0; wr_type = 0; load_level = 0;
  endtask

  initial begin
    int acks, n;
    bit seen;
    vecs[0] = '{85, 170, 5, 10, 0};
    vecs[1] = '{250, 170, 10, 10, 2};
    vecs[2] = '{639, 479, 79, 79, 1};
    vecs[3] = '{240, 400, 0, 0, 3};
    vecs[4] = '{80, 240, 0, 0, 1};
    vecs[5] = '{700, 100, 0, 0, 0};
    vecs[6] = '{100, 480, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 0, 0};

    resetN = 0; pixelX = 0; pixelY = 0; rd_col = 0; rd_row = 0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    resetN = 1;

    // First display lookup after reset.
    pixelX = 85; pixelY = 170;
    tick();
    chk("first_offsetX", offsetX, 5);
    chk("first_offsetY", offsetY, 10);
    chk("first_tile", Tile_type, 0);

    // Single update deferred until vblank.
    pixelY = 100; rd_col = 2; rd_row = 1;
    wr_req = 1; wr_col = 2; wr_row = 1; wr_type = 2;
    tick();
    chk("single_ack", wr_ack, 1);
    wr_req = 0;
    repeat (3) tick();
    chk("deferred_unchanged", rd_type, 0);
    pixelY = 480;
    tick();
    tick();
    chk("single_applied", rd_type, 2);

    // Five back-to-back requests outside vblank: four queued, fifth dropped.
    pixelY = 100; acks = 0;
    for (int i = 0; i < 5; i++) begin
      wr_req = 1; wr_col = 3'(i); wr_row = 3'(4); wr_type = 2'((i % 3) + 1);
      tick();
      acks += int'(wr_ack);
    end
    wr_req = 0;
    chk("burst_acks", acks, 4);
    chk("burst_full", fifo_full, 1);
    pixelY = 480;
    repeat (4) tick();
    chk("burst_drained", fifo_full, 0);
    pixelY = 100;
    for (int i = 0; i < 5; i++) begin
      rd_row = 4; rd_col = 3'(i);
      tick();
      chk("burst_cell", rd_type, (i < 4) ? (i % 3) + 1 : 0);
    end

    // Level load with pending updates that must be discarded.
    pixelY = 100;
    wr_req = 1; wr_col = 0; wr_row = 0; wr_type = 3; tick();
    wr_col = 4; wr_row = 4; wr_type = 2; tick();
    wr_req = 0;
    pixelY = 200; load_req = 1; load_level = 1;
    tick();
    load_req = 0;
    chk("load_busy", busy, 1);
    rd_row = 5; rd_col = 0;
    repeat (3) tick();
    chk("load_pend_nochange", rd_type, 0);
    pixelY = 480; n = 0; seen = 0;
    while (!seen && n < 100) begin
      tick();
      n++;
      seen = load_done;
    end
    chk("load_done_seen", seen, 1);
    chk("load_cycles", n, 49);
    chk("load_busy_clear", busy, 0);
    repeat (4) tick();
    scan_grid(1, 1);

    // Display table over the loaded level.
    pixelY = 0;
    for (int i = 0; i < 8; i++) begin
      pixelX = 11'(vecs[i].px); pixelY = 11'(vecs[i].py);
      tick();
      chk("tbl_offsetX", offsetX, vecs[i].ox);
      chk("tbl_offsetY", offsetY, vecs[i].oy);
      chk("tbl_tile", Tile_type, vecs[i].t);
    end

    // Off-grid row update is acked then discarded.
    pixelX = 10; pixelY = 100;
    wr_req = 1; wr_col = 7; wr_row = 6; wr_type = 2;
    tick();
    chk("offgrid_ack", wr_ack, 1);
    wr_req = 0;
    pixelY = 480;
    repeat (2) tick();
    chk("offgrid_full", fifo_full, 0);
    scan_grid(1, 1);
    pixelX = 700; pixelY = 100;
    tick();
    chk("offscreen_tile", Tile_type, 0);
    chk("offscreen_ox", offsetX, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      pixelX     = 11'($urandom_range(0, 799));
      pixelY     = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(480, 524)) : 11'($urandom_range(0, 479));
      wr_req     = 1'($urandom_range(0, 1));
      wr_col     = 3'($urandom);
      wr_row     = 3'($urandom);
      wr_type    = 2'($urandom);
      load_req   = ($urandom_range(0, 79) == 0);
      load_level = 2'($urandom);
      rd_col     = 3'($urandom);
      rd_row     = 3'($urandom);
      tick();
    end
    idle_inputs();
    pixelY = 480; n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk("random_settle", busy, 0);

    // Reset in the middle of a load.
    pixelY = 200; load_req = 1; load_level = 2;
    tick();
    load_req = 0; pixelY = 480;
    repeat (21) tick();
    chk("midload_busy", busy, 1);
    resetN = 0;
    #2;
    model_reset();
    chk_reset_vals();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1;
    pixelY = 100;
    tick();
    chk("post_reset_busy", busy, 0);
    scan_grid(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tile_grid_controller.md
# tile_grid_controller

Owns the 8x6 tile-type grid for the screen and sequences the per-pixel tile drawer: from the VGA pixel coordinates it produces the tile-relative offsets and the tile type the drawer consumes. It arbitrates grid access between the display read path, game-logic tile updates and level loads from a constant layout table. All grid modifications are deferred to vertical blank so a frame never shows a half-applied update.

## Interface
Parameters:
- TILE_W, 80, tile width in pixels
- TILE_H, 80, tile height in pixels
- GRID_COLS, 8, tiles per row
- GRID_ROWS, 6, tiles per column
- FIFO_DEPTH, 4, pending tile-update entries (power of 2)

Ports:
- clk  in  1  system clock; the block uses this single clock
- resetN  in  1  asynchronous, active-low reset
- pixelX  in  11  current VGA column
- pixelY  in  11  current VGA line
- offsetX  out  11  pixel offset inside current tile (to tile drawer)
- offsetY  out  11  line offset inside current tile (to tile drawer)
- Tile_type  out  2  type of current tile: 00 background, 01 floor, 10 gift, 11 hole
- wr_req  in  1  game-logic tile update request
- wr_col  in  3  update column
- wr_row  in  3  update row
- wr_type  in  2  new tile type
- wr_ack  out  1  one-cycle pulse: request queued
- fifo_full  out  1  update queue full
- load_req  in  1  start a level load
- load_level  in  2  level index 0..3
- busy  out  1  load pending or in progress
- load_done  out  1  one-cycle pulse: load finished
- rd_col  in  3  query column (collision check)
- rd_row  in  3  query row
- rd_type  out  2  type at rd_col/rd_row, registered

## Operation
- Grid: 48 x 2-bit registers, index = row*8 + col (6 bits). Reset clears all to 00.
- Display path: col = pixelX / TILE_W, row = pixelY / TILE_H, offsets = remainders, via constant-divisor comparator chain. Pixel outside 640x480 → Tile_type 00, offsets 0.
- Query path: rd_type = grid[rd_row*8+rd_col]; out-of-range coordinates return 00. Query path never stalls.
- vblank = (pixelY >= 480).
- Update queue: wr_req accepted when not full and state is IDLE; accepted → wr_ack pulses next cycle. Rejected requests are dropped, no ack. Simultaneous push and pop in same cycle allowed when not full.
- Drain: in IDLE with vblank high and queue non-empty, pop one entry per cycle and write grid. Entries with col >= 8 or row >= 6 are popped and discarded.
- States: IDLE → LOAD_PEND on load_req (level latched). LOAD_PEND → LOAD on first cycle with vblank high; entering LOAD flushes the queue. LOAD writes layout[level][i] into grid[i] for i = 0..47, one per cycle, then pulses load_done and returns to IDLE. load_req outside IDLE is ignored.
- busy = state != IDLE.
- Reset at any point (including mid-load): state IDLE, queue empty, grid cleared.

## Timing
- offsetX/offsetY/Tile_type: registered, 1 cycle after pixelX/pixelY; tile drawer adds its own register (total 2 to RGB).
- rd_type: 1 cycle after rd_col/rd_row.
- Grid writes visible on display/query outputs the cycle after the write.
- LOAD lasts exactly 48 cycles; load_done asserted on cycle 49 after LOAD entry, concurrent with return to IDLE.
- Reset values: offsetX 0, offsetY 0, Tile_type 00, rd_type 00, wr_ack 0, fifo_full 0, busy 0, load_done 0.

## Structure
- Package tile_pkg: tile-type localparams (00/01/10/11), grid dimensions, screen limits 640/480, state enum, and the 4x48 constant level-layout array.
- Sub-module tile_locator: pixel coordinate → (col, row, offsetX, offsetY, in_range), combinational; instantiated once for the display path.

## Test plan
- Reset, pixelX=85, pixelY=170 → next cycle offsetX=5, offsetY=10, Tile_type=00.
- wr_req col=2,row=1,type=10 with pixelY=100 → wr_ack next cycle; grid unchanged until pixelY=480; then rd_col=2,rd_row=1 returns 10.
- 5 back-to-back wr_req outside vblank → 4 acks, fifo_full=1, 5th dropped; during vblank 4 writes applied in 4 cycles.
- load_req level=1 at pixelY=200 → busy=1, no grid change until pixelY=480; then 48 writes, load_done pulse, grid equals layout[1], pending queue entries discarded.
- wr_req col=7,row=6 → acked, drained with no grid change; pixelX=700 → Tile_type=00, offsets 0.
- resetN low 20 cycles into LOAD → all outputs at reset values, grid all 00, busy=0 after release.
